// File: rtl/muldiv_iter_pkg.sv
// Shared types for the execute-stage multiply/divide unit: ALU op encoding,
// the iterative unit's state enum and op-classification helpers.
package common;

  localparam int XLEN_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_MUL    = 4'd8,
    ALU_MULH   = 4'd9,
    ALU_MULHSU = 4'd10,
    ALU_MULHU  = 4'd11,
    ALU_DIV    = 4'd12,
    ALU_DIVU   = 4'd13,
    ALU_REM    = 4'd14,
    ALU_REMU   = 4'd15
  } alu_op_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_mul_op(alu_op_type op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div_op(alu_op_type op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_rem_op(alu_op_type op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  // Operand a is interpreted as two's complement for these ops.
  function automatic logic a_is_signed(alu_op_type op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  // Operand b is interpreted as two's complement for these ops.
  function automatic logic b_is_signed(alu_op_type op);
    return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_div_step.sv
// Combinational restoring-division slice: shifts DIV_BITS_PER_CYCLE dividend
// bits (MSB first) into the partial remainder, producing one quotient bit each.
module div_step #(
  parameter int XLEN_WIDTH         = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic [XLEN_WIDTH-1:0]         rem_i,
  input  logic [DIV_BITS_PER_CYCLE-1:0] bits_i,
  input  logic [XLEN_WIDTH-1:0]         divisor_i,
  output logic [XLEN_WIDTH-1:0]         rem_o,
  output logic [DIV_BITS_PER_CYCLE-1:0] quo_o
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [XLEN_WIDTH:0] r;

  // Unrolled shift / trial-subtract / restore chain.
  always_comb begin
    r     = {1'b0, rem_i};
    quo_o = '0;
    for (int i = DIV_BITS_PER_CYCLE - 1; i >= 0; i--) begin
      r = {r[XLEN_WIDTH-1:0], bits_i[i]};
      if (r >= {1'b0, divisor_i}) begin
        r        = r - {1'b0, divisor_i};
        quo_o[i] = 1'b1;
      end
    end
    rem_o = r[XLEN_WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshake,
// result tag and flush.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. out_valid,
// out_result and out_tag hold stable until that transfer. flush outranks both.
module muldiv_iter #(
  parameter int XLEN_WIDTH         = common::XLEN_WIDTH,
  parameter int MUL_BITS_PER_CYCLE = 8,
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH          = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  common::alu_op_type    in_op,
  input  logic [XLEN_WIDTH-1:0] in_a,
  input  logic [XLEN_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy,
  output common::muldiv_state_t dbg_state
);
  import common::*;

  localparam int X         = XLEN_WIDTH;
  localparam int M         = MUL_BITS_PER_CYCLE;
  localparam int K         = DIV_BITS_PER_CYCLE;
  localparam int MW        = X + M;
  localparam int MUL_STEPS = X / M;
  localparam int DIV_STEPS = X / K;
  localparam int MIN_BPC   = (M < K) ? M : K;
  localparam int CNT_W     = $clog2(X / MIN_BPC) + 1;

  muldiv_state_t    state_q, state_d;
  alu_op_type       op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  // Multiplicand for MUL, divisor for DIV.
  logic [X-1:0]     opnd_q, opnd_d;
  // MUL: {accumulator, remaining multiplier}; DIV: {remainder, dividend/quotient}.
  logic [2*X-1:0]   acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X-1:0]     result_q, result_d;

  // Operand decode at accept.
  logic         a_neg, b_neg, div_by_zero, div_ovf;
  logic [X-1:0] a_mag, b_mag, most_neg;

  assign most_neg    = {1'b1, {(X-1){1'b0}}};
  assign a_neg       = a_is_signed(in_op) && in_a[X-1];
  assign b_neg       = b_is_signed(in_op) && in_b[X-1];
  assign a_mag       = a_neg ? -in_a : in_a;
  assign b_mag       = b_neg ? -in_b : in_b;
  assign div_by_zero = (in_b == '0);
  assign div_ovf     = (in_op inside {ALU_DIV, ALU_REM}) && (in_a == most_neg) && (in_b == '1);

  // Multiply step: add multiplicand * low multiplier chunk to the upper half,
  // then shift the whole product register right by one chunk.
  logic [MW-1:0]  partial, hi_sum;
  logic [2*X-1:0] mul_next, mul_signed;
  logic [X-1:0]   mul_res;

  assign partial    = MW'(opnd_q) * MW'(acc_q[M-1:0]);
  assign hi_sum     = MW'(acc_q[2*X-1:X]) + partial;
  assign mul_next   = {hi_sum, acc_q[X-1:M]};
  // Fix-up is fed straight from the final step so the result register loads
  // on the last iteration edge.
  assign mul_signed = neg_q ? -mul_next : mul_next;
  assign mul_res    = (op_q == ALU_MUL) ? mul_signed[X-1:0] : mul_signed[2*X-1:X];

  // Divide step.
  logic [X-1:0]   div_rem, quo_fix, rem_fix, div_res;
  logic [K-1:0]   div_q;
  logic [2*X-1:0] div_next;

  div_step #(
    .XLEN_WIDTH        (X),
    .DIV_BITS_PER_CYCLE(K)
  ) u_div_step (
    .rem_i    (acc_q[2*X-1:X]),
    .bits_i   (acc_q[X-1 -: K]),
    .divisor_i(opnd_q),
    .rem_o    (div_rem),
    .quo_o    (div_q)
  );

  assign div_next = {div_rem, acc_q[X-K-1:0], div_q};
  assign quo_fix  = neg_q     ? -div_next[X-1:0]   : div_next[X-1:0];
  assign rem_fix  = neg_rem_q ? -div_next[2*X-1:X] : div_next[2*X-1:X];
  assign div_res  = is_rem_op(op_q) ? rem_fix : quo_fix;

  // Next-state and datapath-load logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d      = in_op;
          tag_d     = in_tag;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (is_mul_op(in_op)) begin
            state_d = MUL;
            opnd_d  = a_mag;
            acc_d   = {{X{1'b0}}, b_mag};
            cnt_d   = CNT_W'(MUL_STEPS);
          end else if (is_div_op(in_op)) begin
            if (div_by_zero) begin
              state_d  = DONE;
              result_d = is_rem_op(in_op) ? in_a : '1;
            end else if (div_ovf) begin
              state_d  = DONE;
              result_d = is_rem_op(in_op) ? '0 : in_a;
            end else begin
              state_d = DIV;
              opnd_d  = b_mag;
              acc_d   = {{X{1'b0}}, a_mag};
              cnt_d   = CNT_W'(DIV_STEPS);
            end
          end else begin
            state_d  = DONE;
            result_d = '0;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = mul_res;
          state_d  = DONE;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = div_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= ALU_ADD;
      tag_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !flush && !reset;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at default parameters (32-bit, 8 mul bits
// and 1 div bit per cycle). Latency counts the accepting edge as edge 1.
module tb_muldiv_iter;
  import common::*;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  alu_op_type           in_op;
  logic [31:0]          in_a;
  logic [31:0]          in_b;
  logic [4:0]           in_tag;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_result;
  logic [4:0]           out_tag;
  logic                 busy;
  muldiv_state_t        dbg_state;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  muldiv_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Issue one op, wait (bounded) for its result, optionally hold out_ready low
  // for 'hold' cycles while checking the result stays put, then retire it.
  task automatic run_op(input alu_op_type op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                        input int hold, input string name);
    int          lat;
    logic [31:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    e = exp_q.pop_front();
    check({name, " result"}, out_result, e);
    check({name, " tag"}, out_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " held valid"}, out_valid, 1);
      check({name, " held result"}, out_result, e);
      check({name, " held tag"}, out_tag, tag);
      check({name, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({name, " retired valid"}, out_valid, 0);
    check({name, " retired in_ready"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = ALU_ADD;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst out_result", out_result, 0);
    check("rst out_tag", out_tag, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    check("rst state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-rst in_ready", in_ready, 1);

    // Multiply.
    run_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 5'h01, 32'h4000_0000, 5, 0, "mulh_min");
    run_op(ALU_MULHU,  32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000, 5, 0, "mulhu_min");
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 32'hFFFF_FFFF, 5, 0, "mulhsu_ones");
    run_op(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'h0000_0001, 5, 0, "mul_ones");
    run_op(ALU_MUL,    32'hFFFF_FFFD, 32'h0000_0007, 5'h05, 32'hFFFF_FFEB, 5, 0, "mul_neg3x7");
    run_op(ALU_MULH,   32'hFFFF_FFFD, 32'h0000_0007, 5'h06, 32'hFFFF_FFFF, 5, 0, "mulh_neg3x7");

    // Divide.
    run_op(ALU_DIV,  32'hFFFF_FFF3, 32'h0000_0005, 5'h07, 32'hFFFF_FFFE, 33, 0, "div_neg13_5");
    run_op(ALU_REM,  32'hFFFF_FFF3, 32'h0000_0005, 5'h08, 32'hFFFF_FFFD, 33, 0, "rem_neg13_5");
    run_op(ALU_DIVU, 32'hFFFF_0001, 32'h0000_FFFF, 5'h09, 32'h0001_0000, 33, 0, "divu_big");
    run_op(ALU_REMU, 32'hFFFF_0001, 32'h0000_FFFF, 5'h0A, 32'h0000_0001, 33, 0, "remu_big");
    run_op(ALU_DIV,  32'd100,       32'hFFFF_FFF9, 5'h0B, 32'hFFFF_FFF2, 33, 0, "div_100_neg7");
    run_op(ALU_REM,  32'd100,       32'hFFFF_FFF9, 5'h0C, 32'h0000_0002, 33, 0, "rem_100_neg7");

    // Special cases and unsupported op.
    run_op(ALU_DIVU, 32'h0000_1234, 32'h0,         5'h0D, 32'hFFFF_FFFF, 1, 0, "divu_by0");
    run_op(ALU_REMU, 32'h0000_1234, 32'h0,         5'h0E, 32'h0000_1234, 1, 0, "remu_by0");
    run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'h0F, 32'h8000_0000, 1, 0, "div_ovf");
    run_op(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'h10, 32'h0000_0000, 1, 0, "rem_ovf");
    run_op(ALU_REM,  32'hFFFF_FFF9, 32'h0,         5'h11, 32'hFFFF_FFF9, 1, 0, "rem_by0");
    run_op(ALU_ADD,  32'h0000_0003, 32'h0000_0004, 5'h12, 32'h0000_0000, 1, 0, "unsupported");

    // Backpressure: result held for 10 cycles in DONE.
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1A, 32'hFFFF_FFFE, 5, 10, "mulhu_bp");

    // Flush at iteration 10 of a divide.
    @(negedge clk);
    in_valid = 1'b1; in_op = ALU_DIV; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'h13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("div mid state", dbg_state, DIV);
    flush = 1'b1;
    #1;
    check("flush in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush out_valid", out_valid, 0);
    check("flush busy", busy, 0);
    check("flush in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush no result", seen, 0);
    run_op(ALU_MUL, 32'd10, 32'd5, 5'h14, 32'd50, 5, 0, "mul_after_flush");

    // Flush discards a result waiting in DONE.
    @(negedge clk);
    in_valid = 1'b1; in_op = ALU_DIVU; in_a = 32'd1; in_b = 32'd0; in_tag = 5'h15;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("done before flush", out_valid, 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("done flushed", out_valid, 0);
    check("done flushed state", dbg_state, IDLE);
    out_ready = 1'b1;

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; in_op = ALU_MUL; in_a = 32'd9; in_b = 32'd9; in_tag = 5'h07;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid mul busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst out_result", out_result, 0);
    check("mid rst out_tag", out_tag, 0);
    check("mid rst busy", busy, 0);
    check("mid rst in_ready", in_ready, 0);
    check("mid rst state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid rst release in_ready", in_ready, 1);
    run_op(ALU_MULHU, 32'h0001_0000, 32'h0001_0000, 5'h16, 32'h0000_0001, 5, 0, "mulhu_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
